truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Synthesizable sequencer that exhaustively sweeps an N_IN-input combinational block through all 2^N_IN input codes.
- Holds each code for a programmable settle window, samples the block's 1-bit output and compares it against a truth table latched at start.
- Reports per-vector samples, an error count, the first failing code and pass/done status.
- Hardware replacement for delay-based software sweeps of small combinational units such as the three-input gates in this codebase; used for on-chip self-test.

Parameters:
- N_IN, 3, number of DUT inputs; legal range 1..8.
- SETTLE, 4, extra hold cycles per vector before sampling; legal range 0..65535; vector period = SETTLE+1 cycles.
- CNT_W, 16, settle counter width; must satisfy SETTLE < 2^CNT_W.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  begin sweep; sampled in IDLE or DONE only.
- abort  in  1  synchronous abort of a running sweep.
- expected_tt  in  2^N_IN  expected y per code; bit k = expected y for dut_in==k; latched on the start edge.
- dut_in  out  N_IN  drive to the combinational DUT, MSB-first as {a,b,c,...}.
- dut_y  in  1  DUT output.
- busy  out  1  high while sweeping.
- done  out  1  level; high from sweep completion until the next start edge.
- pass  out  1  high only when done=1 and err_count=0.
- err_count  out  N_IN+1  number of mismatching codes in the current or last sweep.
- first_err_idx  out  N_IN  code of first mismatch; 0 if none.
- sample_valid  out  1  one-cycle pulse per sampled vector.
- sample_idx  out  N_IN  code sampled; valid with sample_valid.
- sample_y  out  1  dut_y value sampled; valid with sample_valid.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; every output =0; internal idx, cnt and err_seen =0; latched table =0.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1 at an edge:
  - Go to RUN; latch expected_tt; idx=0; dut_in=0; cnt=SETTLE.
  - busy=1, done=0, pass=0; err_count=0, first_err_idx=0, err_seen=0.
- RUN, each edge with abort=0:
  - If cnt!=0: cnt decrements. dut_in is unchanged.
  - If cnt==0: sample dut_y at this edge.
    - Register sample_valid=1, sample_idx=idx, sample_y=dut_y.
    - On mismatch (dut_y != table[idx]): err_count increments. If err_seen=0, set first_err_idx=idx and err_seen=1.
    - If idx==2^N_IN-1: go to DONE; busy=0; done=1; pass = (final err_count==0), computed including this sample.
    - Otherwise: idx increments; dut_in=idx+1; cnt=SETTLE.
- sample_valid is deasserted on every edge where no sample is taken.
- Timing:
  - Each code is driven for exactly SETTLE+1 cycles.
  - done rises 2^N_IN*(SETTLE+1) edges after the start edge; for N_IN=3, SETTLE=4 this is 40.
  - SETTLE=0: a new code every cycle, and a sample on every RUN edge.
- abort=1 in RUN:
  - Next state IDLE; dut_in=0; busy=0; done=0; pass=0; sample_valid=0.
  - err_count and first_err_idx hold their values.
  - abort has priority over a same-edge sample. abort is ignored in IDLE and DONE.
- start in RUN is ignored.
- start and abort together in IDLE or DONE: start wins.
- DONE holds dut_in at 2^N_IN-1 and all result outputs stable until start or reset.
- err_count cannot overflow: its maximum is 2^N_IN, which fits in N_IN+1 bits.
- Reset asserted mid-sweep returns all outputs to 0 immediately, without waiting for a clock edge.

Test Plan:
- Majority DUT, expected_tt=8'b1110_1000, SETTLE=4, start pulse -> 8 sample_valid pulses 5 cycles apart with sample_idx 0..7; done at edge 40; pass=1; err_count=0.
- DUT with y stuck at 0, same table -> err_count=4, first_err_idx=3, pass=0, done=1; sample_y all 0.
- Reset driven low mid-sweep while dut_in=5 -> all outputs 0 within the same cycle with no clock edge; a later start gives a clean full sweep with pass=1.
- abort at dut_in=2; also start pulsed mid-sweep -> start has no effect; after abort: IDLE, busy=0, done=0, dut_in=0, err_count retained.
- SETTLE=0 build, majority DUT -> dut_in increments every cycle; done at edge 8; 8 consecutive sample_valid cycles.
- From DONE with err_count=4, start with the correct table -> err_count cleared on the start edge; new sweep ends pass=1.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: on-chip exhaustive tester for a small combinational block.
// Walks dut_in through every code, holds each one for SETTLE+1 cycles, samples
// dut_y on the last cycle and compares it with a truth table captured at start.
//
// Handshake: start is a level sampled on the rising edge while the sequencer is
// idle or done. abort is sampled on the rising edge while running. There is no
// backpressure: sample_valid is a one-cycle pulse, and sample_idx/sample_y are
// meaningful only in that cycle.
module truth_table_sweeper #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 4,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2**N_IN-1:0]   expected_tt,
    output logic [N_IN-1:0]      dut_in,
    input  logic                 dut_y,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      first_err_idx,
    output logic                 sample_valid,
    output logic [N_IN-1:0]      sample_idx,
    output logic                 sample_y,
    output logic [1:0]           dbg_state
);

    localparam logic [N_IN-1:0]  LAST_IDX   = N_IN'((1 << N_IN) - 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [2**N_IN-1:0]  tt_q, tt_d;
    logic [N_IN-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_seen_q, err_seen_d;
    logic [N_IN:0]       err_count_q, err_count_d;
    logic [N_IN-1:0]     first_err_q, first_err_d;
    logic                sample_valid_q, sample_valid_d;
    logic [N_IN-1:0]     sample_idx_q, sample_idx_d;
    logic                sample_y_q, sample_y_d;

    // State register and all datapath registers; reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            tt_q           <= '0;
            idx_q          <= '0;
            cnt_q          <= '0;
            err_seen_q     <= 1'b0;
            err_count_q    <= '0;
            first_err_q    <= '0;
            sample_valid_q <= 1'b0;
            sample_idx_q   <= '0;
            sample_y_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            tt_q           <= tt_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            err_seen_q     <= err_seen_d;
            err_count_q    <= err_count_d;
            first_err_q    <= first_err_d;
            sample_valid_q <= sample_valid_d;
            sample_idx_q   <= sample_idx_d;
            sample_y_q     <= sample_y_d;
        end
    end

    // Next-state logic: start from idle/done, settle countdown, sample/compare, abort.
    always_comb begin
        state_d        = state_q;
        tt_d           = tt_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        err_seen_d     = err_seen_q;
        err_count_d    = err_count_q;
        first_err_d    = first_err_q;
        sample_valid_d = 1'b0;
        sample_idx_d   = sample_idx_q;
        sample_y_d     = sample_y_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // abort is meaningless here, so start alone decides.
                if (start) begin
                    state_d     = S_RUN;
                    tt_d        = expected_tt;
                    idx_d       = '0;
                    cnt_d       = CNT_RELOAD;
                    err_seen_d  = 1'b0;
                    err_count_d = '0;
                    first_err_d = '0;
                end
            end
            S_RUN: begin
                if (abort) begin
                    // Results so far are kept for inspection; the sample is dropped.
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    sample_valid_d = 1'b1;
                    sample_idx_d   = idx_q;
                    sample_y_d     = dut_y;
                    if (dut_y != tt_q[idx_q]) begin
                        err_count_d = err_count_q + (N_IN+1)'(1);
                        if (!err_seen_q) begin
                            first_err_d = idx_q;
                            err_seen_d  = 1'b1;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        // dut_in stays on the last code while done.
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + N_IN'(1);
                        cnt_d = CNT_RELOAD;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign dut_in        = idx_q;
    assign busy          = (state_q == S_RUN);
    assign done          = (state_q == S_DONE);
    assign pass          = (state_q == S_DONE) && (err_count_q == '0);
    assign err_count     = err_count_q;
    assign first_err_idx = first_err_q;
    assign sample_valid  = sample_valid_q;
    assign sample_idx    = sample_idx_q;
    assign sample_y      = sample_y_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: main build (N_IN=3, SETTLE=4) and a
// SETTLE=0 build side by side, each wired to a behavioural 3-input DUT.
module tb_truth_table_sweeper;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] expected_tt;
    logic [2:0] dut_in;
    logic       dut_y;
    logic       busy, done, pass;
    logic [3:0] err_count;
    logic [2:0] first_err_idx;
    logic       sample_valid;
    logic [2:0] sample_idx;
    logic       sample_y;
    logic [1:0] dbg_state;

    logic       start_z;
    logic       abort_z;
    logic [2:0] dut_in_z;
    logic       dut_y_z;
    logic       busy_z, done_z, pass_z;
    logic [3:0] err_count_z;
    logic [2:0] first_err_idx_z;
    logic       sample_valid_z;
    logic [2:0] sample_idx_z;
    logic       sample_y_z;
    logic [1:0] dbg_state_z;

    // 0 = majority gate, 1 = output stuck at 0, 2 = output stuck at 1
    int         mode;
    int         n_checks;
    int         n_fail;
    logic [7:0] maj_tt;

    function automatic logic maj3(input logic [2:0] v);
        return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    endfunction

    assign dut_y   = (mode == 0) ? maj3(dut_in) : ((mode == 1) ? 1'b0 : 1'b1);
    assign dut_y_z = maj3(dut_in_z);

    truth_table_sweeper #(.N_IN(3), .SETTLE(4), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .expected_tt(expected_tt), .dut_in(dut_in), .dut_y(dut_y),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_idx(first_err_idx), .sample_valid(sample_valid),
        .sample_idx(sample_idx), .sample_y(sample_y), .dbg_state(dbg_state)
    );

    truth_table_sweeper #(.N_IN(3), .SETTLE(0), .CNT_W(16)) u_dut_z (
        .clk(clk), .rst_n(rst_n), .start(start_z), .abort(abort_z),
        .expected_tt(expected_tt), .dut_in(dut_in_z), .dut_y(dut_y_z),
        .busy(busy_z), .done(done_z), .pass(pass_z), .err_count(err_count_z),
        .first_err_idx(first_err_idx_z), .sample_valid(sample_valid_z),
        .sample_idx(sample_idx_z), .sample_y(sample_y_z), .dbg_state(dbg_state_z)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver helpers (no checking inside)
    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic run_to_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_dut_in(input logic [2:0] code, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dut_in == code) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, pass, err_count, first_err_idx, sample_valid, sample_idx, sample_y, dut_in} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b pass=%b err=%0d first=%0d sv=%b dut_in=%0d, required all 0",
                     busy, done, pass, err_count, first_err_idx, sample_valid, dut_in);
        end
        n_checks++;
        if (dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d required 0", dbg_state);
        end
        n_checks++;
        if ({busy_z, done_z, pass_z, err_count_z, sample_valid_z, dut_in_z} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_settle0: nonzero output, required all 0");
        end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_majority();
        logic       exp_sv;
        logic [2:0] exp_in;
        mode        = 0;
        expected_tt = 8'b1110_1000;
        pulse_start();
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            exp_sv = (k % 5 == 0);
            exp_in = (k < 40) ? 3'(k / 5) : 3'd7;
            n_checks++;
            if (sample_valid !== exp_sv) begin
                n_fail++;
                $display("FAIL maj_sample_valid edge %0d: got %b required %b", k, sample_valid, exp_sv);
            end
            if (exp_sv) begin
                n_checks++;
                if (sample_idx !== 3'(k / 5 - 1) || sample_y !== maj_tt[k / 5 - 1]) begin
                    n_fail++;
                    $display("FAIL maj_sample edge %0d: got idx=%0d y=%b required idx=%0d y=%b",
                             k, sample_idx, sample_y, k / 5 - 1, maj_tt[k / 5 - 1]);
                end
            end
            n_checks++;
            if (dut_in !== exp_in) begin
                n_fail++;
                $display("FAIL maj_dut_in edge %0d: got %0d required %0d", k, dut_in, exp_in);
            end
            n_checks++;
            if (done !== (k == 40) || busy !== (k != 40)) begin
                n_fail++;
                $display("FAIL maj_done edge %0d: got done=%b busy=%b required done=%b", k, done, busy, k == 40);
            end
        end
        n_checks++;
        if (pass !== 1'b1 || err_count !== 4'd0 || first_err_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL maj_result: got pass=%b err=%0d first=%0d required pass=1 err=0 first=0",
                     pass, err_count, first_err_idx);
        end
    endtask

    task automatic test_stuck0();
        int nsamp;
        nsamp       = 0;
        mode        = 1;
        expected_tt = 8'b1110_1000;
        pulse_start();
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (sample_valid) begin
                nsamp++;
                n_checks++;
                if (sample_y !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stuck_sample_y idx %0d: got %b required 0", sample_idx, sample_y);
                end
            end
        end
        n_checks++;
        if (nsamp != 8) begin
            n_fail++;
            $display("FAIL stuck_sample_count: got %0d required 8", nsamp);
        end
        n_checks++;
        if (done !== 1'b1 || pass !== 1'b0 || err_count !== 4'd4 || first_err_idx !== 3'd3) begin
            n_fail++;
            $display("FAIL stuck_result: got done=%b pass=%b err=%0d first=%0d required done=1 pass=0 err=4 first=3",
                     done, pass, err_count, first_err_idx);
        end
    endtask

    task automatic test_restart_from_done();
        bit ok;
        mode = 0;
        expected_tt = 8'b1110_1000;
        // start and abort together in DONE: start must win
        @(negedge clk) begin
            start = 1'b1;
            abort = 1'b1;
        end
        @(negedge clk) begin
            start = 1'b0;
            abort = 1'b0;
        end
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0 || err_count !== 4'd0 ||
            first_err_idx !== 3'd0 || dut_in !== 3'd0) begin
            n_fail++;
            $display("FAIL restart_start_edge: got busy=%b done=%b pass=%b err=%0d first=%0d dut_in=%0d required 1,0,0,0,0,0",
                     busy, done, pass, err_count, first_err_idx, dut_in);
        end
        run_to_done(60, ok);
        n_checks++;
        if (!ok || pass !== 1'b1 || err_count !== 4'd0) begin
            n_fail++;
            $display("FAIL restart_result: got done=%b pass=%b err=%0d required done=1 pass=1 err=0",
                     done, pass, err_count);
        end
    endtask

    task automatic test_reset_mid_sweep();
        bit ok;
        mode = 0;
        expected_tt = 8'b1110_1000;
        pulse_start();
        wait_dut_in(3'd5, 40, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rstmid_reach5: got dut_in=%0d required 5", dut_in);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, pass, err_count, first_err_idx, sample_valid, sample_idx, sample_y, dut_in} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_async: busy=%b done=%b err=%0d dut_in=%0d, required all 0 before any edge",
                     busy, done, err_count, dut_in);
        end
        @(negedge clk) rst_n = 1'b1;
        pulse_start();
        run_to_done(60, ok);
        n_checks++;
        if (!ok || pass !== 1'b1 || err_count !== 4'd0 || dut_in !== 3'd7) begin
            n_fail++;
            $display("FAIL rstmid_resweep: got done=%b pass=%b err=%0d dut_in=%0d required 1,1,0,7",
                     done, pass, err_count, dut_in);
        end
    endtask

    task automatic test_abort();
        bit ok;
        mode = 2;
        // code 0 expects 1 (match), code 1 expects 0 (mismatch with stuck-1)
        expected_tt = 8'b1110_1001;
        pulse_start();
        wait_dut_in(3'd2, 40, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL abort_reach2: got dut_in=%0d required 2", dut_in);
        end
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n_checks++;
        if (dut_in !== 3'd2 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_start_ignored: got dut_in=%0d busy=%b required 2,1", dut_in, busy);
        end
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        n_checks++;
        if (dbg_state !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 ||
            dut_in !== 3'd0 || sample_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got state=%0d busy=%b done=%b pass=%b dut_in=%0d sv=%b required 0,0,0,0,0,0",
                     dbg_state, busy, done, pass, dut_in, sample_valid);
        end
        n_checks++;
        if (err_count !== 4'd1 || first_err_idx !== 3'd1) begin
            n_fail++;
            $display("FAIL abort_retain: got err=%0d first=%0d required err=1 first=1", err_count, first_err_idx);
        end
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        n_checks++;
        if (dbg_state !== 2'd0 || err_count !== 4'd1 || dut_in !== 3'd0) begin
            n_fail++;
            $display("FAIL abort_in_idle: got state=%0d err=%0d dut_in=%0d required 0,1,0", dbg_state, err_count, dut_in);
        end
    endtask

    task automatic test_settle0();
        logic [2:0] exp_in;
        expected_tt = 8'b1110_1000;
        @(negedge clk) start_z = 1'b1;
        @(negedge clk) start_z = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_in = (k < 8) ? 3'(k) : 3'd7;
            n_checks++;
            if (sample_valid_z !== 1'b1 || sample_idx_z !== 3'(k - 1) || sample_y_z !== maj_tt[k - 1]) begin
                n_fail++;
                $display("FAIL s0_sample edge %0d: got sv=%b idx=%0d y=%b required 1,%0d,%b",
                         k, sample_valid_z, sample_idx_z, sample_y_z, k - 1, maj_tt[k - 1]);
            end
            n_checks++;
            if (dut_in_z !== exp_in || done_z !== (k == 8)) begin
                n_fail++;
                $display("FAIL s0_progress edge %0d: got dut_in=%0d done=%b required %0d,%b",
                         k, dut_in_z, done_z, exp_in, k == 8);
            end
        end
        n_checks++;
        if (pass_z !== 1'b1 || err_count_z !== 4'd0) begin
            n_fail++;
            $display("FAIL s0_result: got pass=%b err=%0d required 1,0", pass_z, err_count_z);
        end
        @(negedge clk);
        n_checks++;
        if (sample_valid_z !== 1'b0 || done_z !== 1'b1 || dut_in_z !== 3'd7) begin
            n_fail++;
            $display("FAIL s0_hold: got sv=%b done=%b dut_in=%0d required 0,1,7", sample_valid_z, done_z, dut_in_z);
        end
    endtask

    // Test sequence and summary
    initial begin
        n_checks    = 0;
        n_fail      = 0;
        mode        = 0;
        maj_tt      = 8'b1110_1000;
        rst_n       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        start_z     = 1'b0;
        abort_z     = 1'b0;
        expected_tt = 8'h00;

        test_reset();
        test_majority();
        test_stuck0();
        test_restart_from_done();
        test_reset_mid_sweep();
        test_abort();
        test_settle0();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
